// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP back-end constants, flag indices, state encoding and raw divider result struct
package fp_pkg;

    localparam int MAN_W = 49;
    localparam int EXP_W = 9;
    localparam logic [EXP_W-1:0] EXP_NEG_TH = 9'd384;

    localparam int FP_BIAS = 127;
    localparam logic signed [9:0] FP_EXP_MAX = 10'sd255;
    localparam logic signed [9:0] E_ONE      = 10'sd1;

    localparam int FLAG_OVF  = 3;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_INX  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        DENORM,
        ROUND,
        DONE
    } fp_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } div_raw_t;

endpackage

// File: rtl/div_pack_if.sv
// rtl/div_pack_if.sv - operand/result handshake bundle between divider, packer and writeback
interface div_pack_if;
    logic                       in_valid;
    logic                       in_ready;
    logic                       sign_in;
    logic [fp_pkg::EXP_W-1:0]   exp_in;
    logic [fp_pkg::MAN_W-1:0]   man_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [31:0]                result;
    logic [3:0]                 flags;

    modport master (
        output in_valid, sign_in, exp_in, man_in, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, sign_in, exp_in, man_in, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even increment with carry-out and inexact detection
module fp_round_rne (
    input  logic [23:0] kept,
    input  logic        guard,
    input  logic        sticky,
    output logic [23:0] kept_rnd,
    output logic        carry,
    output logic        inexact
);
    logic up;

    assign up                = guard & (sticky | kept[0]);
    assign {carry, kept_rnd} = {1'b0, kept} + {24'd0, up};
    assign inexact           = guard | sticky;
endmodule

// File: rtl/div_pack.sv
// rtl/div_pack.sv - divide back end: iterative normalise, RNE round, IEEE single pack; DIV_PACK_SUBNORMAL_EN enables gradual underflow
module div_pack
    import fp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    output logic       busy,
    div_pack_if.slave  bus
);
    fp_state_t         state_q, state_d;
    logic              sign_q, sign_d;
    logic signed [9:0] e_q, e_d;
    logic [MAN_W-1:0]  man_q, man_d;
    logic              sticky_q, sticky_d;
    logic              unf_q, unf_d;
    logic [31:0]       result_q, result_d;
    logic [3:0]        flags_q, flags_d;

    div_raw_t          raw;
    logic signed [9:0] e_ld;
    logic [23:0]       kept_rnd, kept_f;
    logic              carry, inexact;
    logic signed [9:0] e_r;
    logic [31:0]       pack_res;
    logic [3:0]        pack_flags;

    assign raw  = '{sign: bus.sign_in, exp: bus.exp_in, man: bus.man_in};
    // Raw exponents in the top quarter of the 9-bit range are negative (wrapped) values.
    assign e_ld = (raw.exp < EXP_NEG_TH) ? $signed({1'b0, raw.exp}) : $signed({1'b1, raw.exp});

    fp_round_rne u_rne (
        .kept     (man_q[47:24]),
        .guard    (man_q[23]),
        .sticky   (sticky_q | (|man_q[22:0])),
        .kept_rnd (kept_rnd),
        .carry    (carry),
        .inexact  (inexact)
    );

    assign kept_f = carry ? 24'h800000 : kept_rnd;
    assign e_r    = e_q + $signed({9'd0, carry});

    always_comb begin
        pack_res   = {sign_q, 31'h0};
        pack_flags = '0;
        if (unf_q) begin
            pack_flags[FLAG_UNF]  = 1'b1;
            pack_flags[FLAG_INX]  = 1'b1;
            pack_flags[FLAG_ZERO] = 1'b1;
        end else if (kept_f == '0) begin
            pack_flags[FLAG_ZERO] = 1'b1;
            pack_flags[FLAG_INX]  = inexact;
            pack_flags[FLAG_UNF]  = inexact;
        end else if (!kept_f[23]) begin
`ifdef DIV_PACK_SUBNORMAL_EN
            pack_res             = {sign_q, 8'h00, kept_f[22:0]};
            pack_flags[FLAG_INX] = inexact;
            pack_flags[FLAG_UNF] = inexact;
`else
            pack_flags[FLAG_UNF]  = 1'b1;
            pack_flags[FLAG_INX]  = 1'b1;
            pack_flags[FLAG_ZERO] = 1'b1;
`endif
        end else if (e_r >= FP_EXP_MAX) begin
            pack_res             = {sign_q, 8'hFF, 23'h0};
            pack_flags[FLAG_OVF] = 1'b1;
            pack_flags[FLAG_INX] = 1'b1;
        end else begin
            pack_res             = {sign_q, e_r[7:0], kept_f[22:0]};
            pack_flags[FLAG_INX] = inexact;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        e_d      = e_q;
        man_d    = man_q;
        sticky_d = sticky_q;
        unf_d    = unf_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (!stall) begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    sign_d   = raw.sign;
                    e_d      = e_ld;
                    man_d    = raw.man;
                    sticky_d = 1'b0;
                    unf_d    = 1'b0;
                    if (raw.man == '0) begin
                        state_d = ROUND;
                    end else if (e_ld <= 10'sd0) begin
`ifdef DIV_PACK_SUBNORMAL_EN
                        state_d = DENORM;
`else
                        unf_d   = 1'b1;
                        state_d = ROUND;
`endif
                    end else begin
                        state_d = NORM;
                    end
                end
                NORM: begin
                    if (man_q[48]) begin
                        man_d    = man_q >> 1;
                        sticky_d = sticky_q | man_q[0];
                        e_d      = e_q + 10'sd1;
                    end else if (!man_q[47] && (e_q > E_ONE)) begin
                        man_d = man_q << 1;
                        e_d   = e_q - 10'sd1;
                    end else begin
                        state_d = ROUND;
                    end
                end
`ifdef DIV_PACK_SUBNORMAL_EN
                DENORM: begin
                    if (e_q == E_ONE) begin
                        state_d = ROUND;
                    end else begin
                        man_d    = man_q >> 1;
                        sticky_d = sticky_q | man_q[0];
                        e_d      = e_q + 10'sd1;
                    end
                end
`endif
                ROUND: begin
                    result_d = pack_res;
                    flags_d  = pack_flags;
                    state_d  = DONE;
                end
                DONE: if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            e_q      <= '0;
            man_q    <= '0;
            sticky_q <= 1'b0;
            unf_q    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            e_q      <= e_d;
            man_q    <= man_d;
            sticky_q <= sticky_d;
            unf_q    <= unf_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_div_pack.sv
// tb/tb_div_pack.sv - directed-vector bench for div_pack; expectations follow DIV_PACK_SUBNORMAL_EN
module tb_div_pack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic busy;

    div_pack_if bus ();

    div_pack dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    // lat counts the accept edge as 1, so an aligned operand reports 3
    task automatic run_vec(input string tag, input logic s, input logic [8:0] ex,
                           input logic [48:0] m, input logic [31:0] want_res,
                           input logic [3:0] want_flags, input int want_lat,
                           input int stall_at, input int hold);
        int lat;
        logic [31:0] first_res;
        @(negedge clk);
        bus.sign_in  = s;
        bus.exp_in   = ex;
        bus.man_in   = m;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            if (stall_at > 0 && lat == stall_at) stall = 1'b1;
            if (stall_at > 0 && lat == stall_at + 5) stall = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        stall = 1'b0;
        check({tag, " out_valid"}, bus.out_valid, 1'b1);
        check({tag, " latency"}, lat, want_lat);
        check({tag, " result"}, bus.result, want_res);
        check({tag, " flags"}, bus.flags, want_flags);
        first_res = bus.result;
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            repeat (hold) @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check({tag, " hold result"}, bus.result, first_res);
            check({tag, " hold out_valid"}, bus.out_valid, 1'b1);
            check({tag, " hold in_ready"}, bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " drain out_valid"}, bus.out_valid, 1'b0);
        check({tag, " drain in_ready"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sign_in   = 1'b0;
        bus.exp_in    = '0;
        bus.man_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", bus.in_ready, 1'b1);
        check("rst out_valid", bus.out_valid, 1'b0);
        check("rst result", bus.result, 32'h0);
        check("rst flags", bus.flags, 4'h0);
        check("rst busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_vec("two", 1'b0, 9'd127, 49'h1_0000_0000_0000, 32'h40000000, 4'b0000, 4, 0, 0);
        run_vec("neg_one", 1'b1, 9'd127, 49'h0_8000_0000_0000, 32'hBF800000, 4'b0000, 3, 0, 0);
        run_vec("tie_even", 1'b0, 9'd127, 49'h0_8000_0080_0000, 32'h3F800000, 4'b0010, 3, 0, 0);
        run_vec("tie_odd", 1'b0, 9'd127, 49'h0_8000_0180_0000, 32'h3F800002, 4'b0010, 3, 0, 0);
        run_vec("lshift7", 1'b0, 9'd127, 49'h0_0100_0000_0000, 32'h3C000000, 4'b0000, 10, 0, 0);
        run_vec("overflow", 1'b0, 9'd254, 49'h1_0000_0000_0000, 32'h7F800000, 4'b1010, 4, 0, 0);
        run_vec("zero", 1'b1, 9'd127, 49'h0, 32'h80000000, 4'b0001, 2, 0, 0);
`ifdef DIV_PACK_SUBNORMAL_EN
        run_vec("underflow", 1'b0, 9'h1F0, 49'h0_8000_0000_0000, 32'h00000040, 4'b0000, 20, 0, 0);
`else
        run_vec("underflow", 1'b0, 9'h1F0, 49'h0_8000_0000_0000, 32'h00000000, 4'b0111, 2, 0, 0);
`endif
        run_vec("stall5", 1'b0, 9'd127, 49'h0_0100_0000_0000, 32'h3C000000, 4'b0000, 15, 3, 0);
        run_vec("hold10", 1'b1, 9'd127, 49'h0_8000_0000_0000, 32'hBF800000, 4'b0000, 3, 0, 10);

        @(negedge clk);
        bus.sign_in  = 1'b0;
        bus.exp_in   = 9'd127;
        bus.man_in   = 49'h0_0100_0000_0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_norm busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort out_valid", bus.out_valid, 1'b0);
        check("abort in_ready", bus.in_ready, 1'b1);
        check("abort result", bus.result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_vec("after_rst", 1'b0, 9'd127, 49'h1_0000_0000_0000, 32'h40000000, 4'b0000, 4, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
